// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Generates the EX-stage ALU operand forward selects and the ID-stage stall.
// A private two-slot shadow (EX, MEM) of in-flight destination registers is
// compared against the ID instruction's sources every cycle.
// Build option: define HAZARD_FWD_EN to enable MEM->EX forwarding of
// non-load distance-1 results. When it is undefined, every distance-1 hit
// stalls and EX_ForwardA is always 00.
module hazard_forward_unit #(
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                ID_Valid,
  input  logic [REG_BITS-1:0] ID_Rs,
  input  logic [REG_BITS-1:0] ID_Rt,
  input  logic                ID_UsesRs,
  input  logic                ID_UsesRt,
  input  logic                ID_ALUSrc,
  input  logic [REG_BITS-1:0] ID_Dest,
  input  logic                ID_RegWrite,
  input  logic                ID_MemRead,
  input  logic                Flush,
  output logic                Stall,
  output logic [1:0]          EX_ForwardA,
  output logic [1:0]          EX_ForwardB,
  output logic [CNT_BITS-1:0] StallCount
);

`ifdef HAZARD_FWD_EN
  localparam logic FWD_PATH = 1'b1;
`else
  localparam logic FWD_PATH = 1'b0;
`endif

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // Shadow slot for the instruction currently in EX
  logic                r_ex_valid;
  logic [REG_BITS-1:0] r_ex_dest;
  logic                r_ex_regwrite;
  logic                r_ex_memread;

  // Shadow slot for the instruction currently in MEM
  logic                r_mem_valid;
  logic [REG_BITS-1:0] r_mem_dest;
  logic                r_mem_regwrite;

  logic [1:0]          r_fwd_a;
  logic [1:0]          r_fwd_b;
  logic [CNT_BITS-1:0] r_stall_cnt;

  logic                w_rs_nz;
  logic                w_rt_nz;
  logic                w_ex_hit_rs;
  logic                w_ex_hit_rt;
  logic                w_mem_hit_rs;
  logic                w_mem_hit_rt;
  logic                w_hit1;
  logic                w_load_hit1;
  logic                w_hit2;
  logic                w_stall;
  logic                w_bubble;
  logic [1:0]          w_fwd_a_nxt;
  logic [1:0]          w_fwd_b_nxt;

  // Source/slot match detection; register 0 is hard-wired and never hits
  always_comb begin
    w_rs_nz      = (ID_Rs != '0);
    w_rt_nz      = (ID_Rt != '0);
    w_ex_hit_rs  = ID_UsesRs & w_rs_nz & r_ex_valid & r_ex_regwrite
                   & (r_ex_dest == ID_Rs);
    w_ex_hit_rt  = ID_UsesRt & w_rt_nz & r_ex_valid & r_ex_regwrite
                   & (r_ex_dest == ID_Rt);
    w_mem_hit_rs = ID_UsesRs & w_rs_nz & r_mem_valid & r_mem_regwrite
                   & (r_mem_dest == ID_Rs);
    w_mem_hit_rt = ID_UsesRt & w_rt_nz & r_mem_valid & r_mem_regwrite
                   & (r_mem_dest == ID_Rt);
    w_hit1       = w_ex_hit_rs | w_ex_hit_rt;
    w_load_hit1  = w_hit1 & r_ex_memread;
    w_hit2       = w_mem_hit_rs | w_mem_hit_rt;
  end

  // Stall decision and bubble injection; a flush always overrides a stall
  always_comb begin
    w_stall  = ID_Valid & ~Flush
               & (w_load_hit1 | w_hit2 | (w_hit1 & ~FWD_PATH));
    w_bubble = w_stall | Flush | ~ID_Valid;
  end

  // Next forward selects for the instruction entering EX
  always_comb begin
    w_fwd_a_nxt = SEL_REG;
    w_fwd_b_nxt = SEL_REG;
    if (!w_bubble) begin
      if (FWD_PATH && w_ex_hit_rs && !r_ex_memread)
        w_fwd_a_nxt = SEL_MEM;
      if (ID_ALUSrc)
        w_fwd_b_nxt = SEL_IMM;
      else if (FWD_PATH && w_ex_hit_rt && !r_ex_memread)
        w_fwd_b_nxt = SEL_MEM;
    end
  end

  // Shadow pipeline advance: MEM takes EX, EX takes ID or a bubble
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ex_valid     <= 1'b0;
      r_ex_dest      <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_dest     <= '0;
      r_mem_regwrite <= 1'b0;
    end else begin
      r_mem_valid    <= r_ex_valid;
      r_mem_dest     <= r_ex_dest;
      r_mem_regwrite <= r_ex_regwrite;
      if (w_bubble) begin
        r_ex_valid    <= 1'b0;
        r_ex_dest     <= '0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
      end else begin
        r_ex_valid    <= 1'b1;
        r_ex_dest     <= ID_Dest;
        r_ex_regwrite <= ID_RegWrite;
        r_ex_memread  <= ID_MemRead;
      end
    end
  end

  // Registered forward selects, aligned with the instruction now in EX
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fwd_a <= SEL_REG;
      r_fwd_b <= SEL_REG;
    end else begin
      r_fwd_a <= w_fwd_a_nxt;
      r_fwd_b <= w_fwd_b_nxt;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + CNT_BITS'(1);
  end

  assign Stall       = w_stall;
  assign EX_ForwardA = r_fwd_a;
  assign EX_ForwardB = r_fwd_b;
  assign StallCount  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit
// Directed instruction sequences for hazard_forward_unit. Each driven cycle
// pushes its expected {Stall, ForwardA, ForwardB, StallCount}; a monitor pops
// and compares at the falling edge. StallCount is narrowed to 3 bits so that
// saturation is reachable in a short run.
module tb_hazard_forward_unit;

  localparam int unsigned REG_BITS = 5;
  localparam int unsigned CNT_BITS = 3;

  logic                Clk;
  logic                Reset_n;
  logic                ID_Valid;
  logic [REG_BITS-1:0] ID_Rs;
  logic [REG_BITS-1:0] ID_Rt;
  logic                ID_UsesRs;
  logic                ID_UsesRt;
  logic                ID_ALUSrc;
  logic [REG_BITS-1:0] ID_Dest;
  logic                ID_RegWrite;
  logic                ID_MemRead;
  logic                Flush;
  logic                Stall;
  logic [1:0]          EX_ForwardA;
  logic [1:0]          EX_ForwardB;
  logic [CNT_BITS-1:0] StallCount;

  hazard_forward_unit #(
    .REG_BITS(REG_BITS),
    .CNT_BITS(CNT_BITS)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .ID_Valid    (ID_Valid),
    .ID_Rs       (ID_Rs),
    .ID_Rt       (ID_Rt),
    .ID_UsesRs   (ID_UsesRs),
    .ID_UsesRt   (ID_UsesRt),
    .ID_ALUSrc   (ID_ALUSrc),
    .ID_Dest     (ID_Dest),
    .ID_RegWrite (ID_RegWrite),
    .ID_MemRead  (ID_MemRead),
    .Flush       (Flush),
    .Stall       (Stall),
    .EX_ForwardA (EX_ForwardA),
    .EX_ForwardB (EX_ForwardB),
    .StallCount  (StallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int    stall;
    int    fa;
    int    fb;
    int    cnt;
    string nm;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Monitor: one expectation per driven cycle, sampled mid-cycle
  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.nm, ".stall"}, int'(Stall),       e.stall);
      check({e.nm, ".fwdA"},  int'(EX_ForwardA), e.fa);
      check({e.nm, ".fwdB"},  int'(EX_ForwardB), e.fb);
      check({e.nm, ".cnt"},   int'(StallCount),  e.cnt);
    end
  end

  task automatic push(input int es, input int efa, input int efb,
                      input int ecnt, input string nm);
    exp_t e;
    e.stall = es; e.fa = efa; e.fb = efb; e.cnt = ecnt; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic set_in(input bit v, input int rs, input int rt, input bit urs,
                        input bit urt, input bit als, input int dst,
                        input bit rw, input bit mr, input bit fl);
    ID_Valid    = v;
    ID_Rs       = REG_BITS'(rs);
    ID_Rt       = REG_BITS'(rt);
    ID_UsesRs   = urs;
    ID_UsesRt   = urt;
    ID_ALUSrc   = als;
    ID_Dest     = REG_BITS'(dst);
    ID_RegWrite = rw;
    ID_MemRead  = mr;
    Flush       = fl;
  endtask

  // One pipeline cycle: drive ID, queue what must be visible this cycle
  task automatic cyc(input bit v, input int rs, input int rt, input bit urs,
                     input bit urt, input bit als, input int dst, input bit rw,
                     input bit mr, input bit fl, input int es, input int efa,
                     input int efb, input int ecnt, input string nm);
    set_in(v, rs, rt, urs, urt, als, dst, rw, mr, fl);
    push(es, efa, efb, ecnt, nm);
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int efa, input int efb, input int ecnt,
                      input string nm);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, efa, efb, ecnt, nm);
  endtask

  task automatic do_reset(input string nm);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    Reset_n = 1'b0;
    push(0, 0, 0, 0, nm);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  // Reset pulse inside one clock-high/low window, with no rising edge
  task automatic rst_mid(input bit v, input int rs, input int rt, input bit urs,
                         input bit urt, input bit als, input int dst,
                         input bit rw, input bit mr, input string nm);
    set_in(v, rs, rt, urs, urt, als, dst, rw, mr, 1'b0);
    #1;
    Reset_n = 1'b0;
    push(0, 0, 0, 0, nm);
    @(negedge Clk);
    #2;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk);
    #1;
    do_reset("rst0");

    // Distance-1 ALU dependency
`ifdef HAZARD_FWD_EN
    cyc(1, 1, 2, 1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, "a1_add3");
    cyc(1, 3, 5, 1, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0, "a2_add4_3_5");
    idle(2, 0, 0, "a3_fwdA");
    cyc(1, 1, 2, 1, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, "a4_add5");
    cyc(1, 0, 5, 1, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0, "a5_and6_0_5");
    idle(0, 2, 0, "a6_fwdB");
`else
    cyc(1, 1, 2, 1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, "a1_add3");
    cyc(1, 3, 3, 1, 1, 0, 4, 1, 0, 0, 1, 0, 0, 0, "a2_dep_stall1");
    cyc(1, 3, 3, 1, 1, 0, 4, 1, 0, 0, 1, 0, 0, 1, "a3_dep_stall2");
    cyc(1, 3, 3, 1, 1, 0, 4, 1, 0, 0, 0, 0, 0, 2, "a4_dep_issue");
    idle(0, 0, 2, "a5_noFwd");
`endif

    // Load-use at distance 1
    do_reset("rst_b");
    cyc(1, 1, 0, 1, 0, 1, 3, 1, 1, 0, 0, 0, 0, 0, "b1_lw3");
    cyc(1, 5, 3, 1, 1, 0, 4, 1, 0, 0, 1, 0, 1, 0, "b2_lu_stall1");
    cyc(1, 5, 3, 1, 1, 0, 4, 1, 0, 0, 1, 0, 0, 1, "b3_lu_stall2");
    cyc(1, 5, 3, 1, 1, 0, 4, 1, 0, 0, 0, 0, 0, 2, "b4_lu_issue");
    idle(0, 0, 2, "b5_after");

    // Distance-2 dependency through a nop
    do_reset("rst_c");
    cyc(1, 1, 2, 1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, "c1_add3");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "c2_nop");
    cyc(1, 3, 3, 1, 1, 0, 6, 1, 0, 0, 1, 0, 0, 0, "c3_d2_stall");
    cyc(1, 3, 3, 1, 1, 0, 6, 1, 0, 0, 0, 0, 0, 1, "c4_d2_issue");
    idle(0, 0, 1, "c5_after");

    // Writes to $0 never hit; flush beats a load-use stall
    do_reset("rst_d");
    cyc(1, 1, 2, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, "d1_add0");
    cyc(1, 0, 0, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, "d2_addi_r0");
    cyc(1, 1, 0, 1, 0, 1, 3, 1, 1, 0, 0, 0, 1, 0, "d3_lw3_immB");
    cyc(1, 5, 3, 1, 1, 0, 4, 1, 0, 0, 1, 0, 1, 0, "d4_lu_stall");
    cyc(1, 5, 3, 1, 1, 0, 4, 1, 0, 1, 0, 0, 0, 1, "d5_flush");
    cyc(1, 4, 4, 1, 1, 0, 7, 1, 0, 0, 0, 0, 0, 1, "d6_use4_nohit");
    idle(0, 0, 1, "d7_after");

    // Asynchronous reset in the middle of a load-use stall
    do_reset("rst_e");
    cyc(1, 1, 0, 1, 0, 1, 3, 1, 1, 0, 0, 0, 0, 0, "e1_lw3");
    cyc(1, 5, 3, 1, 1, 0, 4, 1, 0, 0, 1, 0, 1, 0, "e2_lu_stall");
    rst_mid(1, 5, 3, 1, 1, 0, 4, 1, 0, "e3_async_rst");
    cyc(1, 5, 3, 1, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0, "e4_reissue");
    idle(0, 0, 0, "e5_after");

    // Load at distance 1 on A plus ALU result at distance 2 on B
    do_reset("rst_g");
    cyc(1, 1, 2, 1, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, "g1_add5");
    cyc(1, 1, 0, 1, 0, 1, 3, 1, 1, 0, 0, 0, 0, 0, "g2_lw3");
    cyc(1, 3, 5, 1, 1, 0, 6, 1, 0, 0, 1, 0, 1, 0, "g3_both_stall1");
    cyc(1, 3, 5, 1, 1, 0, 6, 1, 0, 0, 1, 0, 0, 1, "g4_both_stall2");
    cyc(1, 3, 5, 1, 1, 0, 6, 1, 0, 0, 0, 0, 0, 2, "g5_both_issue");
    idle(0, 0, 2, "g6_after");

    // Chained load-use pairs drive the 3-bit counter into saturation
    do_reset("rst_f");
    cyc(1, 1, 0, 1, 0, 1, 3, 1, 1, 0, 0, 0, 0, 0, "f1_lw3");
    cyc(1, 3, 0, 1, 0, 1, 4, 1, 1, 0, 1, 0, 1, 0, "f2");
    cyc(1, 3, 0, 1, 0, 1, 4, 1, 1, 0, 1, 0, 0, 1, "f3");
    cyc(1, 3, 0, 1, 0, 1, 4, 1, 1, 0, 0, 0, 0, 2, "f4");
    cyc(1, 4, 0, 1, 0, 1, 5, 1, 1, 0, 1, 0, 1, 2, "f5");
    cyc(1, 4, 0, 1, 0, 1, 5, 1, 1, 0, 1, 0, 0, 3, "f6");
    cyc(1, 4, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0, 0, 4, "f7");
    cyc(1, 5, 0, 1, 0, 1, 6, 1, 1, 0, 1, 0, 1, 4, "f8");
    cyc(1, 5, 0, 1, 0, 1, 6, 1, 1, 0, 1, 0, 0, 5, "f9");
    cyc(1, 5, 0, 1, 0, 1, 6, 1, 1, 0, 0, 0, 0, 6, "f10");
    cyc(1, 6, 0, 1, 0, 1, 7, 1, 1, 0, 1, 0, 1, 6, "f11");
    cyc(1, 6, 0, 1, 0, 1, 7, 1, 1, 0, 1, 0, 0, 7, "f12_sat");
    cyc(1, 6, 0, 1, 0, 1, 7, 1, 1, 0, 0, 0, 0, 7, "f13_hold");
    idle(0, 1, 7, "f14_after");

    // Let the monitor consume the remaining expectations, bounded
    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge Clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
